// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit engine: FSM states,
// data-length encodings and the baud divisor table.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  function automatic int unsigned rdiv(input int unsigned num, input int unsigned den);
    return (num + den / 2) / den;
  endfunction

  // Each branch divides two constants, so the table folds at elaboration.
  function automatic int unsigned baud_div(input logic [3:0] sel, input int unsigned clk_hz);
    case (sel)
      4'd0:    return rdiv(clk_hz, 300);
      4'd1:    return rdiv(clk_hz, 1200);
      4'd2:    return rdiv(clk_hz, 2400);
      4'd3:    return rdiv(clk_hz, 4800);
      4'd4:    return rdiv(clk_hz, 9600);
      4'd5:    return rdiv(clk_hz, 19200);
      4'd6:    return rdiv(clk_hz, 38400);
      4'd7:    return rdiv(clk_hz, 57600);
      4'd8:    return rdiv(clk_hz, 115200);
      4'd9:    return rdiv(clk_hz, 230400);
      4'd10:   return rdiv(clk_hz, 460800);
      default: return rdiv(clk_hz, 921600);
    endcase
  endfunction

  function automatic logic [7:0] len_mask(input logic [1:0] len);
    case (len)
      LEN_5:   return 8'h1F;
      LEN_6:   return 8'h3F;
      LEN_7:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-around pointers, occupancy count and
// full/empty flags; read data is the current head word.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: buffers processor writes in a FIFO and serialises
// them with per-frame sampled format, parity, stop bits and break support.
module uart_tx_fifo_engine
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DIV_OVERRIDE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   baud,
  input  logic [1:0]                   len,
  input  logic                         parity_en,
  input  logic                         odd_n_even,
  input  logic                         two_stop,
  input  logic                         brk,
  input  logic                         load,
  input  logic [7:0]                   out_port,
  output logic                         tx,
  output logic                         txrdy,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  tx_state_e   state_q, state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [1:0]  len_q, len_d;
  logic        par_en_q, par_en_d;
  logic        two_stop_q, two_stop_d;
  logic        rel_q, rel_d;
  logic        tx_q, tx_d;
  logic        overflow_q, overflow_d;

  logic        pop, full, empty;
  logic [7:0]  rdata, masked;
  logic [31:0] cur_div, cnt_next;
  logic        bit_end;
  logic [2:0]  last_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (load & ~full),
    .wdata (out_port),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign cur_div    = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE : baud_div(baud, CLK_HZ);
  assign bit_end    = (baud_cnt_q == div_q - 32'd1);
  assign cnt_next   = bit_end ? '0 : baud_cnt_q + 32'd1;
  assign last_data  = 3'd4 + {1'b0, len_q};
  assign masked     = rdata & len_mask(len);
  assign overflow_d = load & full;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = '0;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    rel_d      = rel_q;
    tx_d       = 1'b1;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Line drops in the same cycle brk is seen, so tx low tracks brk exactly.
        tx_d = ~brk;
        if (brk) begin
          state_d = ST_BREAK;
          div_d   = cur_div;
          rel_d   = 1'b0;
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        tx_d       = 1'b0;
        baud_cnt_d = cnt_next;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        tx_d       = shift_q[0];
        baud_cnt_d = cnt_next;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == last_data) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d       = par_q;
        baud_cnt_d = cnt_next;
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        tx_d       = 1'b1;
        baud_cnt_d = cnt_next;
        if (bit_end) begin
          if (bit_cnt_q[0] == two_stop_q) begin
            if (!empty && !brk) pop = 1'b1;
            else                state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_BREAK: begin
        // The release bit time starts in the first cycle brk is seen low.
        tx_d = rel_q | ~brk;
        if (rel_q || !brk) begin
          rel_d      = 1'b1;
          baud_cnt_d = cnt_next;
          if (bit_end) begin
            if (!empty && !brk) pop = 1'b1;
            else                state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      state_d    = ST_START;
      baud_cnt_d = '0;
      shift_d    = masked;
      par_d      = (^masked) ^ odd_n_even;
      len_d      = len;
      par_en_d   = parity_en;
      two_stop_d = two_stop;
      div_d      = cur_div;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      div_q      <= 32'd1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      len_q      <= LEN_8;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      rel_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      rel_q      <= rel_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign txrdy    = ~full;
  assign tx_busy  = (state_q != ST_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench for uart_tx_fifo_engine: the line is logged every clock
// and compared against per-cycle waveforms built from frame-format rules.
module tb_uart_tx_fifo_engine;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] baud = 4'd8;
  logic [1:0] len = 2'b11;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       two_stop = 1'b0;
  logic       brk = 1'b0;
  logic       load = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       tx, txrdy, tx_busy, overflow;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  logic txlog[$];
  logic exp_q[$];

  uart_tx_fifo_engine #(
    .FIFO_DEPTH   (4),
    .CLK_HZ       (100_000_000),
    .DIV_OVERRIDE (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud       (baud),
    .len        (len),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .two_stop   (two_stop),
    .brk        (brk),
    .load       (load),
    .out_port   (out_port),
    .tx         (tx),
    .txrdy      (txrdy),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // txlog[k] holds the line value just after rising edge k.
  always @(posedge clk) begin
    #1;
    txlog.push_back(tx);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_level(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  function automatic void push_frame(input logic [7:0] d, input logic [1:0] l,
                                     input logic pe, input logic odd, input logic two);
    int nb   = 5 + int'(l);
    int ones = 0;
    push_level(1'b0, DIV);
    for (int i = 0; i < nb; i++) begin
      push_level(d[i], DIV);
      ones += int'(d[i]);
    end
    if (pe) push_level(((ones % 2) == 1) ^ odd, DIV);
    push_level(1'b1, two ? 2 * DIV : DIV);
  endfunction

  task automatic set_cfg(input logic [1:0] l, input logic pe, input logic odd, input logic two);
    len = l; parity_en = pe; odd_n_even = odd; two_stop = two;
  endtask

  // Called just after a falling edge; returns the index of the edge that samples the load.
  task automatic load_byte(input logic [7:0] d, output int idx);
    idx = txlog.size();
    load = 1'b1;
    out_port = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    int guard = 0;
    while (txlog.size() < k && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_wave(input string tag, input int start);
    int n = exp_q.size();
    int guard = 0;
    int m, w;
    while (txlog.size() < start + n && guard < n + 200) begin
      @(negedge clk);
      guard++;
    end
    if (txlog.size() < start + n) begin
      check({tag, "_timeout"}, txlog.size(), start + n);
    end else begin
      check({tag, "_pre"}, txlog[start-1], 1);
      for (int c = 0; c < n; c += DIV) begin
        m = 0;
        w = (n - c < DIV) ? n - c : DIV;
        for (int j = 0; j < w; j++) if (txlog[start+c+j] === exp_q[c+j]) m++;
        check($sformatf("%s_bit%0d", tag, c / DIV), m, w);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    int n, b, k, cnt;
    logic [1:0] rl;
    logic rpe, rodd, rtwo;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_txrdy", txrdy, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);

    // 8 data bits, odd parity, one stop
    set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
    load_byte(8'h0F, n);
    push_frame(8'h0F, 2'b11, 1'b1, 1'b1, 1'b0);
    check("t1_len", exp_q.size(), 176);
    check_wave("t1", n + 2);
    check("t1_txrdy", txrdy, 1);
    check("t1_idle", tx_busy, 0);

    // 5 data bits, even parity, two stop
    set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
    load_byte(8'h15, n);
    push_frame(8'h15, 2'b00, 1'b1, 1'b0, 1'b1);
    check("t2_len", exp_q.size(), 144);
    check_wave("t2", n + 2);

    // Six loads into a 4-deep FIFO
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    n = txlog.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        check("t3_cnt3", fifo_count, 3);
        check("t3_rdy3", txrdy, 1);
      end
      if (i == 5) begin
        check("t3_cnt_full", fifo_count, 4);
        check("t3_rdy_full", txrdy, 0);
        check("t3_ovf_pre", overflow, 0);
      end
      load = 1'b1;
      out_port = 8'(i + 1);
      @(negedge clk);
    end
    load = 1'b0;
    check("t3_ovf", overflow, 1);
    check("t3_cnt_drop", fifo_count, 4);
    @(negedge clk);
    check("t3_ovf_end", overflow, 0);
    for (int i = 1; i <= 5; i++) push_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0);
    check_wave("t3", n + 2);
    check("t3_idle", tx_busy, 0);

    // Break for 100 clocks with a byte queued behind it
    b = txlog.size();
    brk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      load = (i == 5);
      out_port = 8'h55;
      if (i == 50) begin
        check("t4_busy", tx_busy, 1);
        check("t4_cnt", fifo_count, 1);
      end
      @(negedge clk);
    end
    load = 1'b0;
    brk = 1'b0;
    push_level(1'b0, 100);
    push_level(1'b1, DIV);
    push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    check_wave("t4", b);

    // Reset during the third data bit
    load_byte(8'hA5, n);
    load_byte(8'h3C, k);
    wait_idx(n + 2 + 3 * DIV + 5);
    check("t5_cnt_pre", fifo_count, 1);
    check("t5_busy_pre", tx_busy, 1);
    reset = 1'b0;
    #1;
    check("t5_tx", tx, 1);
    check("t5_txrdy", txrdy, 1);
    check("t5_count", fifo_count, 0);
    check("t5_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    k = txlog.size();
    push_level(1'b1, 4 * DIV);
    check_wave("t5_quiet", k);

    // Format change mid-frame applies only to the next frame
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
    load_byte(8'hC3, n);
    wait_idx(n + 30);
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    load_byte(8'h1B, k);
    push_frame(8'hC3, 2'b11, 1'b1, 1'b0, 1'b0);
    push_frame(8'h1B, 2'b00, 1'b0, 1'b1, 1'b1);
    check_wave("t6", n + 2);

    // Randomised bursts of frames
    for (int it = 0; it < 8; it++) begin
      rl   = 2'($urandom_range(0, 3));
      rpe  = 1'($urandom_range(0, 1));
      rodd = 1'($urandom_range(0, 1));
      rtwo = 1'($urandom_range(0, 1));
      set_cfg(rl, rpe, rodd, rtwo);
      cnt = $urandom_range(1, 4);
      n = txlog.size();
      for (int j = 0; j < cnt; j++) begin
        d = 8'($urandom);
        load = 1'b1;
        out_port = d;
        push_frame(d, rl, rpe, rodd, rtwo);
        @(negedge clk);
      end
      load = 1'b0;
      check_wave($sformatf("rnd%0d", it), n + 2);
      check($sformatf("rnd%0d_idle", it), tx_busy, 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo_engine.md
# uart_tx_fifo_engine

Parametrised UART transmit engine, successor to the single-buffer transmit engine. It accepts bytes from the processor output port into an internal FIFO and serialises them onto `tx` with a selectable baud rate. Data length is selectable (5–8 bits), parity and stop-bit count are selectable, and break generation is supported. It sits between the processor I/O decode (`load`/`out_port`) and the UART pin.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLK_HZ`, 100_000_000: system clock frequency, used to build the baud divisor table.
- `DIV_OVERRIDE`, 0: when non-zero, every bit lasts exactly this many clocks and `baud` is ignored (simulation only).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `baud`  in  4  rate select: 0:300, 1:1200, 2:2400, 3:4800, 4:9600, 5:19200, 6:38400, 7:57600, 8:115200, 9:230400, 10:460800, 11–15:921600.
- `len`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `parity_en`  in  1  insert a parity bit after the data bits.
- `odd_n_even`  in  1  1=odd parity, 0=even parity.
- `two_stop`  in  1  1=two stop bits, 0=one stop bit.
- `brk`  in  1  request a break (line held low).
- `load`  in  1  write strobe for `out_port`.
- `out_port`  in  8  write data; bits above `len` are ignored.
- `tx`  out  1  serial line; idles high.
- `txrdy`  out  1  FIFO not full.
- `tx_busy`  out  1  state is not IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
- `overflow`  out  1  one-cycle pulse when a `load` is dropped.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Reset values: `tx`=1, `txrdy`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0. FIFO and all counters are cleared.
- Write rule:
  - `load`=1 with `txrdy`=1 pushes `out_port`.
  - `load`=1 with `txrdy`=0 is dropped and pulses `overflow`, even if a pop happens in the same cycle.
- IDLE transitions:
  - If `brk`=1, go to BREAK. This has priority over a non-empty FIFO.
  - Otherwise, if the FIFO is non-empty, pop the head word and go to START.
  - The pop also samples `len`, `parity_en`, `odd_n_even`, `two_stop` and the divisor. These are frozen for the whole frame.
- Frame sequence:
  - START: `tx`=0.
  - DATA: data bits, LSB first.
  - PARITY: sent only if enabled. Value is the XOR of the data bits, inverted when `odd_n_even`=1.
  - STOP: `tx`=1 for 1 or 2 bit times.
- Back-to-back frames: at the end of STOP, if the FIFO is non-empty and `brk`=0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- BREAK:
  - `tx`=0 while `brk`=1.
  - After `brk` falls, hold `tx`=1 for one full bit time, then return to IDLE.
  - `brk` asserted mid-frame takes effect only after the frame completes.
- Reset mid-frame: the frame is aborted immediately and `tx` goes high. Nothing resumes after reset is released.

## Timing
- Bit time = DIV clocks.
  - DIV = `DIV_OVERRIDE` if non-zero.
  - Otherwise DIV = round(`CLK_HZ`/rate), e.g. 868 for 115200 at 100 MHz.
  - Each bit lasts exactly DIV clocks; there is no cumulative drift.
- Latency from idle: `load` sampled on edge N → pop on edge N+1 → `tx` falls after edge N+2.
- `txrdy` and `fifo_count` update one cycle after a push or pop.
- Frame length = 1 + len + parity_en + (1 or 2) bit times.
- `overflow` is high for exactly the cycle after the dropped `load`.

## Structure
- Package `uart_pkg`:
  - state enum;
  - `len` encoding constants;
  - baud divisor function `baud_div(sel, clk_hz)`.
- Sub-module `uart_tx_fifo`: synchronous FIFO with wrap-around pointers, count and full/empty flags.
- Baud counter, bit counter and shift register stay in the top level.

## Test plan
All scenarios use `DIV_OVERRIDE`=16.
1. `len`=11, odd parity, one stop, load 0x0F → `tx` = 0,1,1,1,1,0,0,0,0,1(parity),1. Each bit is 16 clocks, 176 clocks total; `txrdy` stays 1.
2. `len`=00, even parity, `two_stop`=1, load 0x15 → `tx` = 0,1,0,1,0,1,1(parity),1,1. 9 bits, 144 clocks.
3. Six consecutive loads 0x01–0x06 while idle:
   - the first is popped, and the FIFO is full after the fifth load;
   - the sixth is dropped with an `overflow` pulse and `txrdy`=0;
   - 0x01–0x05 are sent back-to-back with no idle gap.
4. `brk`=1 for 100 clocks while idle, FIFO holding 0x55 → `tx` low for the whole assertion. After release, `tx` is high for 16 clocks before the 0x55 start bit.
5. `reset` low during the third data bit → `tx`=1, `txrdy`=1 and `fifo_count`=0 asynchronously. After release, `tx` stays high.
6. Toggle `parity_en` and `len` mid-frame → the current frame keeps its sampled format, and the next frame uses the new settings.
